// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    IFETCH_WAIT = 2'd1,
    DREAD_WAIT  = 2'd2
  } state_e;

  // Which requester owns the memory port in the current IDLE cycle.
  typedef enum logic [1:0] {
    GNT_FETCH = 2'd0,
    GNT_WRITE = 2'd1,
    GNT_READ  = 2'd2
  } grant_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wentry_t;

  localparam logic [3:0] MASK_ALL = 4'b1111;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write buffer: circular store with an extra wrap bit on each pointer
// so that full and empty are distinguishable without a separate count.
module wbuf_fifo
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  wentry_t entry_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output wentry_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  wentry_t     mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  // Pointer update; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PTR_ONE;
      if (pop_ok)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // Entry storage; contents are don't-care until pointed at.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wptr_q[AW-1:0]] <= entry_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch, data reads and
// posted data writes. One transaction outstanding at a time.
//
//   state       | meaning
//   IDLE        | presenting a request (write head > data read > fetch)
//   IFETCH_WAIT | fetch accepted, waiting for mem_rvalid
//   DREAD_WAIT  | data read accepted, waiting for mem_rvalid
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int WBUF_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        valid,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic [3:0]  write_mask,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wbuf_overflow
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  // A presented-but-not-accepted request is frozen so that a late write or
  // pc change cannot alter what the memory sees before it accepts.
  logic        hold_q, hold_d;
  grant_e      hold_gnt_q, hold_gnt_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic        ovf_q, ovf_d;

  grant_e      gnt;
  logic [31:0] req_addr;
  logic [CW-1:0] cnt_inc;
  logic        pop, full, empty;
  wentry_t     head, wr_entry;

  assign wr_entry.addr = address;
  assign wr_entry.data = write_data;
  assign wr_entry.mask = write_mask;

  wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (write_enable),
    .entry_i (wr_entry),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign cnt_inc = (cnt_q == LIMIT) ? cnt_q : cnt_q + CNT_ONE;

  // Grant selection: frozen request first, then starvation override, then priority.
  always_comb begin
    gnt      = GNT_FETCH;
    req_addr = pc;
    if (hold_q)              gnt = hold_gnt_q;
    else if (cnt_q == LIMIT) gnt = GNT_FETCH;
    else if (!empty)         gnt = GNT_WRITE;
    else if (read_enable)    gnt = GNT_READ;
    if (gnt == GNT_WRITE)    req_addr = head.addr;
    else if (hold_q)         req_addr = hold_addr_q;
    else if (gnt == GNT_READ) req_addr = address;
  end

  // Next-state, memory request and response strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fetch_pc_d  = fetch_pc_q;
    hold_d      = 1'b0;
    hold_gnt_d  = hold_gnt_q;
    hold_addr_d = hold_addr_q;
    pop         = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wmask   = '0;
    valid       = 1'b0;
    instruction = '0;
    read_valid  = 1'b0;
    read_data   = '0;
    case (state_q)
      IDLE: begin
        mem_req   = 1'b1;
        mem_we    = (gnt == GNT_WRITE);
        mem_addr  = req_addr;
        mem_wdata = (gnt == GNT_WRITE) ? head.data : '0;
        mem_wmask = (gnt == GNT_WRITE) ? head.mask : MASK_ALL;
        if (mem_ready) begin
          case (gnt)
            GNT_WRITE: begin
              pop   = 1'b1;
              cnt_d = cnt_inc;
            end
            GNT_READ: begin
              state_d = DREAD_WAIT;
              cnt_d   = cnt_inc;
            end
            default: begin
              state_d    = IFETCH_WAIT;
              fetch_pc_d = req_addr;
              cnt_d      = '0;
            end
          endcase
        end else begin
          hold_d      = 1'b1;
          hold_gnt_d  = gnt;
          hold_addr_d = req_addr;
        end
      end
      IFETCH_WAIT: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          // A redirected pc makes the returning word stale; drop it.
          if (pc == fetch_pc_q) begin
            valid       = 1'b1;
            instruction = mem_rdata;
          end
        end
      end
      DREAD_WAIT: begin
        if (mem_rvalid) begin
          state_d    = IDLE;
          read_valid = 1'b1;
          read_data  = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      pop       = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wmask = '0;
      valid     = 1'b0;
      instruction = '0;
      read_valid  = 1'b0;
      read_data   = '0;
    end
  end

  assign ovf_d = ovf_q || (write_enable && full && !pop);
  assign wbuf_overflow = ovf_q;

  // State registers; reset abandons any outstanding transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fetch_pc_q  <= '0;
      hold_q      <= 1'b0;
      hold_gnt_q  <= GNT_FETCH;
      hold_addr_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fetch_pc_q  <= fetch_pc_d;
      hold_q      <= hold_d;
      hold_gnt_q  <= hold_gnt_d;
      hold_addr_q <= hold_addr_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, address, write_data, instruction, read_data;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        write_enable, read_enable, valid, read_valid;
  logic        mem_req, mem_we, mem_ready, mem_rvalid, wbuf_overflow;
  logic [3:0]  write_mask, mem_wmask;

  int n_cmp = 0;
  int n_bad = 0;

  logic        auto_en = 1'b1;
  logic        man_rv = 1'b0;
  logic [31:0] man_rd = '0;
  logic        model_rv = 1'b0;
  logic [31:0] model_rd = '0;
  logic [31:0] merge_w;
  logic [31:0] mem_m [logic [31:0]];

  typedef struct {
    int          kind;   // 0 fetch, 1 write, 2 data read
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } txn_t;
  txn_t log_q[$];

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] pcv;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
  } vec_t;
  vec_t vt[4];

  assign mem_rvalid = model_rv | man_rv;
  assign mem_rdata  = man_rv ? man_rd : model_rd;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .pc(pc), .instruction(instruction), .valid(valid),
    .address(address), .write_data(write_data), .write_enable(write_enable),
    .write_mask(write_mask), .read_enable(read_enable), .read_data(read_data),
    .read_valid(read_valid), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wbuf_overflow(wbuf_overflow)
  );

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: logs every accept, applies writes, answers reads one cycle later.
  always @(posedge clk) begin
    model_rv <= 1'b0;
    if (!rst && mem_req && mem_ready) begin
      log_q.push_back('{kind: (mem_we ? 1 : (mem_addr[31] ? 0 : 2)),
                        addr: mem_addr, data: mem_wdata, mask: mem_wmask});
      if (mem_we) begin
        merge_w = rd_word(mem_addr);
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) merge_w[8*b +: 8] = mem_wdata[8*b +: 8];
        mem_m[mem_addr] = merge_w;
      end else if (auto_en) begin
        model_rv <= 1'b1;
        model_rd <= rd_word(mem_addr);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1; write_enable = 1'b0; read_enable = 1'b0;
    mem_ready = rdy; man_rv = 1'b0; auto_en = 1'b1;
    @(negedge clk);
    log_q.delete();
    rst = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    write_enable = 1'b1; address = a; write_data = d; write_mask = m;
  endtask

  function automatic int n_writes();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].kind == 1) n++;
    return n;
  endfunction

  // Compare the idx-th logged write against the expected entry.
  task automatic chk_wr(input string nm, input int idx, input logic [31:0] ea,
                        input logic [31:0] ed, input logic [3:0] em);
    int seen = 0;
    foreach (log_q[i]) begin
      if (log_q[i].kind == 1) begin
        if (seen == idx) begin
          chk({nm, " addr"}, log_q[i].addr, ea);
          chk({nm, " data"}, log_q[i].data, ed);
          chk({nm, " mask"}, {28'd0, log_q[i].mask}, {28'd0, em});
        end
        seen++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wi, ri, got;
    int exp_kind[10];

    vt[0] = '{1'b0, 32'h0000_0100, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'hF};
    vt[1] = '{1'b1, 32'h0000_0104, 32'h8000_0000, 1'b0, 32'h0000_0104, 4'hF};
    vt[2] = '{1'b1, 32'h0000_0FFC, 32'h8000_1234, 1'b0, 32'h0000_0FFC, 4'hF};
    vt[3] = '{1'b0, 32'h0000_0200, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 4'hF};

    pc = 32'h8000_0000; address = '0; write_data = '0; write_mask = '0;
    write_enable = 1'b0; read_enable = 1'b0; mem_ready = 1'b0; rst = 1'b1;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst valid", {31'd0, valid}, 32'd0);
    chk("rst read_valid", {31'd0, read_valid}, 32'd0);
    chk("rst overflow", {31'd0, wbuf_overflow}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst instruction", instruction, 32'd0);
    chk("rst read_data", read_data, 32'd0);

    // Table: fresh IDLE grant between read and fetch
    foreach (vt[i]) begin
      rst = 1'b1; mem_ready = 1'b0; write_enable = 1'b0;
      read_enable = vt[i].rd; address = vt[i].addr; pc = vt[i].pcv;
      @(negedge clk);
      chk($sformatf("vec%0d req in rst", i), {31'd0, mem_req}, 32'd0);
      rst = 1'b0;
      #1;
      chk($sformatf("vec%0d mem_req", i), {31'd0, mem_req}, 32'd1);
      chk($sformatf("vec%0d mem_we", i), {31'd0, mem_we}, {31'd0, vt[i].exp_we});
      chk($sformatf("vec%0d mem_addr", i), mem_addr, vt[i].exp_addr);
      chk($sformatf("vec%0d mem_wmask", i), {28'd0, mem_wmask}, {28'd0, vt[i].exp_mask});
    end
    read_enable = 1'b0;

    // Fetch only, minimum latency
    pc = 32'h8000_0000;
    do_reset(1'b1);
    #1;
    chk("fetch req", {31'd0, mem_req}, 32'd1);
    chk("fetch addr", mem_addr, 32'h8000_0000);
    chk("fetch we", {31'd0, mem_we}, 32'd0);
    chk("fetch valid early", {31'd0, valid}, 32'd0);
    @(negedge clk);
    chk("fetch valid", {31'd0, valid}, 32'd1);
    chk("fetch instr", instruction, rd_word(32'h8000_0000));

    // Store then load
    do_reset(1'b1);
    push_wr(32'h100, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    write_enable = 1'b0; read_enable = 1'b1; address = 32'h100;
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clk);
      if (read_valid) begin
        got = 1;
        chk("st_ld read_data", read_data, 32'hDEAD_BEEF);
      end
    end
    read_enable = 1'b0;
    chk("st_ld read_valid seen", got, 1);
    wi = -1; ri = -1;
    foreach (log_q[i]) begin
      if (log_q[i].kind == 1 && wi < 0) wi = i;
      if (log_q[i].kind == 2 && ri < 0) ri = i;
    end
    chk("st_ld write before read", {31'd0, (wi >= 0 && ri > wi)}, 32'd1);
    chk_wr("st_ld wr", 0, 32'h100, 32'hDEAD_BEEF, 4'hF);

    // Two stores while memory stalls for 5 cycles
    do_reset(1'b0);
    push_wr(32'h300, 32'h1111_1111, 4'hF);
    @(negedge clk);
    push_wr(32'h304, 32'h2222_2222, 4'b0011);
    @(negedge clk);
    write_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("stall overflow", {31'd0, wbuf_overflow}, 32'd0);
    chk("stall held addr", mem_addr, 32'h8000_0000);
    mem_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("drain count", n_writes(), 2);
    chk_wr("drain0", 0, 32'h300, 32'h1111_1111, 4'hF);
    chk_wr("drain1", 1, 32'h304, 32'h2222_2222, 4'b0011);
    chk("drain overflow", {31'd0, wbuf_overflow}, 32'd0);

    // Push and pop together while full
    do_reset(1'b0);
    push_wr(32'h600, 32'hA0A0_0001, 4'hF);
    @(negedge clk);
    push_wr(32'h604, 32'hA0A0_0002, 4'hF);
    @(negedge clk);
    write_enable = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1;
    push_wr(32'h608, 32'hA0A0_0003, 4'hF);
    @(negedge clk);
    write_enable = 1'b0;
    chk("full push+pop overflow", {31'd0, wbuf_overflow}, 32'd0);
    repeat (8) @(negedge clk);
    chk("full push+pop count", n_writes(), 3);
    chk_wr("fpp0", 0, 32'h600, 32'hA0A0_0001, 4'hF);
    chk_wr("fpp2", 2, 32'h608, 32'hA0A0_0003, 4'hF);

    // Third store into a full buffer
    do_reset(1'b0);
    push_wr(32'h310, 32'h3333_3333, 4'hF);
    @(negedge clk);
    push_wr(32'h314, 32'h4444_4444, 4'hF);
    @(negedge clk);
    push_wr(32'h318, 32'h5555_5555, 4'hF);
    @(negedge clk);
    write_enable = 1'b0;
    chk("full overflow set", {31'd0, wbuf_overflow}, 32'd1);
    mem_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("ovf drain count", n_writes(), 2);
    chk_wr("ovf0", 0, 32'h310, 32'h3333_3333, 4'hF);
    chk_wr("ovf1", 1, 32'h314, 32'h4444_4444, 4'hF);
    chk("overflow sticky", {31'd0, wbuf_overflow}, 32'd1);

    // Starvation: continuous reads, fetch every fifth grant
    pc = 32'h8000_0000; address = 32'h400;
    do_reset(1'b1);
    read_enable = 1'b1;
    repeat (30) @(negedge clk);
    read_enable = 1'b0;
    exp_kind = '{2, 2, 2, 2, 0, 2, 2, 2, 2, 0};
    chk("starve log length", {31'd0, (log_q.size() >= 10)}, 32'd1);
    for (int i = 0; i < 10 && i < log_q.size(); i++)
      chk($sformatf("starve kind%0d", i), log_q[i].kind, exp_kind[i]);

    // Redirect while a fetch is outstanding
    pc = 32'h8000_0010;
    do_reset(1'b1);
    auto_en = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0; pc = 32'h8000_0040;
    @(negedge clk); @(negedge clk);
    man_rv = 1'b1; man_rd = 32'hCAFE_F00D;
    #2;
    chk("redir valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    man_rv = 1'b0;
    #1;
    chk("redir first addr", (log_q.size() > 0) ? log_q[0].addr : 32'hX, 32'h8000_0010);
    chk("redir next req", {31'd0, mem_req}, 32'd1);
    chk("redir next addr", mem_addr, 32'h8000_0040);

    // Reset in DREAD_WAIT, late response afterwards
    pc = 32'h8000_0000; address = 32'h200;
    do_reset(1'b1);
    auto_en = 1'b0; read_enable = 1'b1;
    @(negedge clk);
    read_enable = 1'b0;
    push_wr(32'h500, 32'h7777_7777, 4'hF);
    @(negedge clk);
    write_enable = 1'b0; rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; man_rv = 1'b1; man_rd = 32'hBAD0_BAD0;
    #2;
    chk("late rv read_valid", {31'd0, read_valid}, 32'd0);
    chk("late rv valid", {31'd0, valid}, 32'd0);
    chk("late rv idle req", {31'd0, mem_req}, 32'd1);
    chk("late rv no write", {31'd0, mem_we}, 32'd0);
    chk("late rv fetch addr", mem_addr, 32'h8000_0000);
    @(negedge clk);
    man_rv = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, max consecutive data grants while a fetch waits.
REQ-002 SHALL have parameter WBUF_DEPTH, default 2, write-buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports pc in 32 fetch address; instruction out 32 fetched word; valid out 1 fetch-response strobe.
REQ-006 SHALL have ports address in 32, write_data in 32, write_enable in 1, write_mask in 4, read_enable in 1 (core data side); read_data out 32, read_valid out 1.
REQ-007 SHALL have memory ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_wmask out 4, mem_ready in 1 (accept), mem_rvalid in 1, mem_rdata in 32.
REQ-008 SHALL have port wbuf_overflow  out  1  sticky error flag.

Function
REQ-009 SHALL hold at most one memory transaction outstanding; a request is accepted in a cycle where mem_req and mem_ready are both 1.
REQ-010 SHALL use FSM states IDLE, IFETCH_WAIT, DREAD_WAIT; writes complete on accept and leave FSM in IDLE.
REQ-011 SHALL capture {address, write_data, write_mask} into the write buffer in every cycle write_enable=1, without back-pressure.
REQ-012 SHALL, in IDLE, grant in priority: write-buffer head (if non-empty), then data read (read_enable=1 and buffer empty), then fetch of pc.
REQ-013 SHALL override REQ-012 and grant fetch when the data-grant counter equals STARVE_LIMIT; counter resets to 0 on each fetch grant.
REQ-014 SHALL drive mem_req/mem_we/mem_addr/mem_wdata/mem_wmask combinationally from the IDLE grant and hold them stable until accepted; mem_we=0, mem_wmask=4'b1111 for reads.
REQ-015 SHALL on fetch accept record the issued pc and go to IFETCH_WAIT; on data-read accept go to DREAD_WAIT.
REQ-016 SHALL in IFETCH_WAIT on mem_rvalid drive instruction=mem_rdata and valid=1 in that same cycle if pc equals recorded pc, else drop the response (valid=0); return to IDLE either way.
REQ-017 SHALL in DREAD_WAIT on mem_rvalid drive read_data=mem_rdata and read_valid=1 in that same cycle, return to IDLE.
REQ-018 SHALL not treat read_enable as a new request in the cycle read_valid=1 (core pipeline advances at that edge).
REQ-019 SHALL ignore mem_rvalid while in IDLE.
REQ-020 SHALL on simultaneous push and pop in one cycle keep occupancy unchanged, including when full.
REQ-021 SHALL on push while full with no pop discard the new write and set wbuf_overflow=1 until reset.
REQ-022 SHALL hold valid and read_valid at 0 in all cycles other than REQ-016/017; instruction and read_data are don't-care when their strobe is 0.
REQ-023 SHALL give minimum latency: fetch request cycle t accepted, mem_rvalid at t+1 -> valid at t+1.

Reset
REQ-024 SHALL on rst=1 at a clock edge enter IDLE, empty the write buffer, clear grant counter and wbuf_overflow, abandon any outstanding transaction.
REQ-025 SHALL drive valid=0, read_valid=0, mem_req=0, wbuf_overflow=0 during and immediately after reset; instruction/read_data/mem_addr/mem_wdata reset to 0.

Structure
REQ-026 SHALL place the state enum (IDLE, IFETCH_WAIT, DREAD_WAIT) and the write-entry struct {addr[31:0], data[31:0], mask[3:0]} in package mem_arbiter_pkg.
REQ-027 SHALL implement the write buffer as sub-module wbuf_fifo (push, pop, full, empty, head) with wrap-around pointers.

Verification
REQ-028 Fetch only: pc=0x80000000, mem_ready=1, memory latency 1 -> mem_req fetch addr 0x80000000, valid=1 one cycle later with memory word.
REQ-029 Store then load: write_enable to 0x100 data 0xDEADBEEF mask 4'b1111, read_enable 0x100 next cycle -> write accepted before read issues, read_data=0xDEADBEEF.
REQ-030 Back-to-back stores with mem_ready=0 for 5 cycles: two stores -> both drained in order, wbuf_overflow=0; third store while full -> wbuf_overflow=1.
REQ-031 Starvation: read_enable held, reads issued continuously -> fetch granted after exactly 4 data grants.
REQ-032 Redirect: fetch 0x80000010 outstanding, pc changed to 0x80000040 before mem_rvalid -> valid=0, next fetch issues 0x80000040.
REQ-033 Reset mid-read in DREAD_WAIT, late mem_rvalid after reset -> read_valid stays 0, FSM IDLE, buffer empty.
